// File: rtl/pacoblaze_scratch_pkg.sv
// Shared types and default parameter values for the PacoBlaze dual-port scratch-pad.
package pacoblaze_scratch_pkg;

    localparam int DEFAULT_WIDTH          = 8;
    localparam int DEFAULT_DEPTH_LOG2     = 6;
    localparam int DEFAULT_CLEAR_ON_RESET = 1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

endpackage

// File: rtl/pacoblaze_scratch_mem.sv
// Scratch-pad array: combinational port-A read, registered port-B read,
// write priority clear > port A > port B.
module pacoblaze_scratch_mem
    import pacoblaze_scratch_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_enable,
    input  logic [DEPTH_LOG2-1:0] clear_address,
    input  logic                  a_write_enable,
    input  logic [DEPTH_LOG2-1:0] a_address,
    input  logic [WIDTH-1:0]      a_data_in,
    output logic [WIDTH-1:0]      a_data_out,
    input  logic                  b_write_enable,
    input  logic [DEPTH_LOG2-1:0] b_write_address,
    input  logic [WIDTH-1:0]      b_write_data,
    input  logic                  b_read_enable,
    input  logic [DEPTH_LOG2-1:0] b_read_address,
    output logic [WIDTH-1:0]      b_read_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    assign a_data_out = mem[a_address];

    // NOTE: the array itself has no reset so it maps onto RAM primitives;
    // zeroing is done by the clear sequencer one word per cycle instead.
    always_ff @(posedge clk) begin
        if (clear_enable) begin
            mem[clear_address] <= '0;
        end else begin
            if (b_write_enable && !(a_write_enable && a_address == b_write_address))
                mem[b_write_address] <= b_write_data;
            if (a_write_enable)
                mem[a_address] <= a_data_in;
        end
    end

    // NOTE: non-blocking assignment makes the port-B load see the pre-write
    // word when a write to the same address lands on the same edge.
    always_ff @(posedge clk) begin
        if (!reset)
            b_read_data <= '0;
        else if (b_read_enable)
            b_read_data <= mem[b_read_address];
    end

endmodule

// File: rtl/pacoblaze_scratch_dp.sv
// Dual-port scratch-pad top: CPU port A, host burst port B with valid/ready
// handshakes and a wrapping pointer, plus the optional post-reset clear.
module pacoblaze_scratch_dp
    import pacoblaze_scratch_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2     = DEFAULT_DEPTH_LOG2,
    parameter int CLEAR_ON_RESET = DEFAULT_CLEAR_ON_RESET
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    input  logic [DEPTH_LOG2-1:0] a_address,
    input  logic                  a_write_enable,
    input  logic [WIDTH-1:0]      a_data_in,
    output logic [WIDTH-1:0]      a_data_out,
    input  logic                  b_start,
    input  logic                  b_write,
    input  logic [DEPTH_LOG2-1:0] b_address,
    input  logic [DEPTH_LOG2-1:0] b_length,
    input  logic                  b_wvalid,
    input  logic [WIDTH-1:0]      b_wdata,
    output logic                  b_wready,
    output logic                  b_rvalid,
    output logic [WIDTH-1:0]      b_rdata,
    input  logic                  b_rready,
    output logic                  b_done
);

    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                  state, state_next;
    logic [DEPTH_LOG2-1:0]   pointer, remaining, clear_count;
    logic [DEPTH_LOG2-1:0]   read_address;
    logic                    load_burst, read_enable, done_next;
    logic                    write_beat, read_beat;
    logic [WIDTH-1:0]        mem_a_data;

    assign busy       = (state == ST_CLEAR);
    assign b_wready   = (state == ST_WRITE);
    assign b_rvalid   = (state == ST_READ);
    assign write_beat = b_wready && b_wvalid;
    assign read_beat  = b_rvalid && b_rready;
    assign a_data_out = busy ? '0 : mem_a_data;

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next   = state;
        load_burst   = 1'b0;
        read_enable  = 1'b0;
        read_address = pointer + ADDR_ONE;
        done_next    = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clear_count == '1)
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (b_start) begin
                    load_burst = 1'b1;
                    if (b_write) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next   = ST_READ;
                        read_enable  = 1'b1;
                        read_address = b_address;
                    end
                end
            end
            ST_WRITE: begin
                if (write_beat && remaining == '0) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            ST_READ: begin
                if (read_beat) begin
                    if (remaining == '0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        read_enable = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RESET_STATE;
            clear_count <= '0;
            pointer     <= '0;
            remaining   <= '0;
            b_done      <= 1'b0;
        end else begin
            state  <= state_next;
            b_done <= done_next;
            if (busy)
                clear_count <= clear_count + ADDR_ONE;
            if (load_burst) begin
                pointer   <= b_address;
                remaining <= b_length;
            end else if (write_beat || read_beat) begin
                pointer   <= pointer + ADDR_ONE;
                remaining <= remaining - ADDR_ONE;
            end
        end
    end

    pacoblaze_scratch_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk             (clk),
        .reset           (reset),
        .clear_enable    (busy),
        .clear_address   (clear_count),
        .a_write_enable  (a_write_enable && !busy),
        .a_address       (a_address),
        .a_data_in       (a_data_in),
        .a_data_out      (mem_a_data),
        .b_write_enable  (write_beat),
        .b_write_address (pointer),
        .b_write_data    (b_wdata),
        .b_read_enable   (read_enable),
        .b_read_address  (read_address),
        .b_read_data     (b_rdata)
    );

endmodule

// File: tb/tb_pacoblaze_scratch_dp.sv
// Directed self-checking bench for pacoblaze_scratch_dp: port-A vector table
// plus hand-written burst, collision and reset sequences.
module tb_pacoblaze_scratch_dp;

    localparam int WIDTH = 8;
    localparam int DL2   = 6;
    localparam int WORDS = 2**DL2;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy;
    logic [DL2-1:0]   a_address;
    logic             a_write_enable;
    logic [WIDTH-1:0] a_data_in;
    logic [WIDTH-1:0] a_data_out;
    logic             b_start;
    logic             b_write;
    logic [DL2-1:0]   b_address;
    logic [DL2-1:0]   b_length;
    logic             b_wvalid;
    logic [WIDTH-1:0] b_wdata;
    logic             b_wready;
    logic             b_rvalid;
    logic [WIDTH-1:0] b_rdata;
    logic             b_rready;
    logic             b_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (b_done === 1'b1) done_pulses++;

    pacoblaze_scratch_dp #(
        .WIDTH          (WIDTH),
        .DEPTH_LOG2     (DL2),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .busy           (busy),
        .a_address      (a_address),
        .a_write_enable (a_write_enable),
        .a_data_in      (a_data_in),
        .a_data_out     (a_data_out),
        .b_start        (b_start),
        .b_write        (b_write),
        .b_address      (b_address),
        .b_length       (b_length),
        .b_wvalid       (b_wvalid),
        .b_wdata        (b_wdata),
        .b_wready       (b_wready),
        .b_rvalid       (b_rvalid),
        .b_rdata        (b_rdata),
        .b_rready       (b_rready),
        .b_done         (b_done)
    );

    typedef struct {
        logic [DL2-1:0]   addr;
        logic             we;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_out;
    } a_vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from now; optionally pokes port A and b_start mid-clear.
    task automatic wait_clear(input bit inject, output int cycles);
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy !== 1'b1) break;
            if (inject && cycles >= 20 && cycles < 25) begin
                a_write_enable = 1'b1;
                a_address      = 6'h05;
                a_data_in      = 8'h77;
                b_start        = 1'b1;
                b_write        = 1'b1;
                #3;
                check("a_data_out_forced_zero_in_clear", a_data_out, 0);
                check("b_wready_low_in_clear", b_wready, 0);
            end else begin
                a_write_enable = 1'b0;
                b_start        = 1'b0;
            end
            cycles++;
            tick();
        end
        a_write_enable = 1'b0;
        b_start        = 1'b0;
    endtask

    a_vec_t avec [8];
    logic [WIDTH-1:0] burst_data [4];
    int clear_cycles;
    int pulses_before;

    initial begin
        reset = 1'b0; a_address = '0; a_write_enable = 1'b0; a_data_in = '0;
        b_start = 1'b0; b_write = 1'b0; b_address = '0; b_length = '0;
        b_wvalid = 1'b0; b_wdata = '0; b_rready = 1'b0;

        avec[0] = '{6'h00, 1'b0, 8'h00, 8'h00};
        avec[1] = '{6'h03, 1'b1, 8'hA5, 8'h00};
        avec[2] = '{6'h03, 1'b0, 8'h00, 8'hA5};
        avec[3] = '{6'h03, 1'b1, 8'h5A, 8'hA5};
        avec[4] = '{6'h03, 1'b0, 8'h00, 8'h5A};
        avec[5] = '{6'h3F, 1'b1, 8'hC3, 8'h00};
        avec[6] = '{6'h3F, 1'b0, 8'h00, 8'hC3};
        avec[7] = '{6'h00, 1'b0, 8'h00, 8'h00};
        burst_data[0] = 8'h11; burst_data[1] = 8'h22;
        burst_data[2] = 8'h33; burst_data[3] = 8'h44;

        // Reset state and clear duration
        repeat (3) tick();
        check("reset_busy", busy, 1);
        check("reset_wready", b_wready, 0);
        check("reset_rvalid", b_rvalid, 0);
        check("reset_rdata", b_rdata, 0);
        check("reset_done", b_done, 0);
        reset = 1'b1;
        wait_clear(1'b1, clear_cycles);
        check("clear_cycles", clear_cycles, WORDS);
        check("idle_after_clear_wready", b_wready, 0);

        for (int i = 0; i < WORDS; i++) begin
            a_address = DL2'(i);
            #1;
            check("zero_after_clear", a_data_out, 0);
        end

        // Port A vector table
        foreach (avec[i]) begin
            a_address = avec[i].addr;
            a_write_enable = avec[i].we;
            a_data_in = avec[i].din;
            #3;
            check($sformatf("porta_vec%0d", i), a_data_out, avec[i].exp_out);
            tick();
        end
        a_write_enable = 1'b0;

        // Port B write burst across the top address, with valid gaps
        pulses_before = done_pulses;
        b_start = 1'b1; b_write = 1'b1; b_address = 6'h3E; b_length = 6'd3;
        tick();
        b_start = 1'b0;
        check("bw_wready_after_start", b_wready, 1);
        for (int i = 0; i < 4; i++) begin
            b_wvalid = 1'b0;
            if (i == 1) begin
                b_start = 1'b1; b_write = 1'b0; b_address = 6'h20; b_length = 6'd0;
            end
            tick();
            b_start = 1'b0;
            check("bw_wready_in_burst", b_wready, 1);
            check("bw_no_early_done", b_done, 0);
            b_wvalid = 1'b1; b_wdata = burst_data[i];
            tick();
        end
        b_wvalid = 1'b0;
        check("bw_done_pulse", b_done, 1);
        check("bw_wready_drop", b_wready, 0);
        tick();
        check("bw_done_one_cycle", b_done, 0);
        check("bw_single_done", done_pulses - pulses_before, 1);
        a_address = 6'h3E; #1; check("mem_3e", a_data_out, 8'h11);
        a_address = 6'h3F; #1; check("mem_3f", a_data_out, 8'h22);
        a_address = 6'h00; #1; check("mem_00", a_data_out, 8'h33);
        a_address = 6'h01; #1; check("mem_01", a_data_out, 8'h44);

        // Port B read burst with rready toggling
        b_start = 1'b1; b_write = 1'b0; b_address = 6'h3E; b_length = 6'd3;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("br_rvalid", b_rvalid, 1);
            check("br_rdata", b_rdata, burst_data[i]);
            b_rready = 1'b0;
            tick();
            check("br_rdata_held", b_rdata, burst_data[i]);
            b_rready = 1'b1;
            tick();
        end
        b_rready = 1'b0;
        check("br_rvalid_drop", b_rvalid, 0);
        check("br_done", b_done, 1);
        tick();

        // Same-address collision: port A wins, beat still counted
        b_start = 1'b1; b_write = 1'b1; b_address = 6'h10; b_length = 6'd1;
        tick();
        b_start = 1'b0;
        b_wvalid = 1'b1; b_wdata = 8'h55;
        a_write_enable = 1'b1; a_address = 6'h10; a_data_in = 8'hAA;
        tick();
        a_write_enable = 1'b0;
        b_wdata = 8'h66;
        tick();
        b_wvalid = 1'b0;
        check("coll_done_after_two_beats", b_done, 1);
        check("coll_wready_drop", b_wready, 0);
        a_address = 6'h10; #1; check("coll_mem_10", a_data_out, 8'hAA);
        a_address = 6'h11; #1; check("coll_mem_11", a_data_out, 8'h66);

        // Streaming read with rready held high, then back-to-back start on b_done
        b_rready = 1'b1;
        b_start = 1'b1; b_write = 1'b0; b_address = 6'h10; b_length = 6'd1;
        tick();
        b_start = 1'b0;
        check("stream_rdata0", b_rdata, 8'hAA);
        tick();
        check("stream_rvalid1", b_rvalid, 1);
        check("stream_rdata1", b_rdata, 8'h66);
        tick();
        check("stream_rvalid_drop", b_rvalid, 0);
        check("stream_done", b_done, 1);
        b_start = 1'b1; b_write = 1'b0; b_address = 6'h03; b_length = 6'd0;
        tick();
        b_start = 1'b0;
        check("b2b_rvalid", b_rvalid, 1);
        check("b2b_rdata", b_rdata, 8'h5A);
        tick();
        check("b2b_rvalid_drop", b_rvalid, 0);
        check("b2b_done", b_done, 1);
        b_rready = 1'b0;
        tick();

        // Reset mid read burst
        b_start = 1'b1; b_write = 1'b0; b_address = 6'h00; b_length = 6'd5;
        tick();
        b_start = 1'b0;
        check("rst_burst_rvalid", b_rvalid, 1);
        b_rready = 1'b1;
        tick();
        pulses_before = done_pulses;
        reset = 1'b0; b_rready = 1'b0;
        tick();
        check("rst_mid_rvalid", b_rvalid, 0);
        check("rst_mid_busy", busy, 1);
        check("rst_mid_rdata", b_rdata, 0);
        reset = 1'b1;
        wait_clear(1'b0, clear_cycles);
        check("rst_clear_cycles", clear_cycles, WORDS);
        check("rst_no_done", done_pulses - pulses_before, 0);
        a_address = 6'h03; #1; check("rst_mem_cleared", a_data_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
